// File: rtl/surfturf_wb_splitter_pkg.sv
// surfturf_wb_splitter_pkg
//   Shared definitions for the surfturf Wishbone splitter: default parameter
//   values, the splitter FSM state type with its state constants, and a small
//   saturating-increment helper used by the timeout statistics counter.
package surfturf_wb_splitter_pkg;

  localparam int SURFTURF_NUM_SLV_DEF = 8;
  localparam int SURFTURF_SLV_AW_DEF  = 6;
  localparam int SURFTURF_ADR_W_DEF   = 12;
  localparam int SURFTURF_TIMEOUT_DEF = 255;

  typedef logic [1:0] wbs_state_t;

  localparam wbs_state_t ST_IDLE = 2'd0;
  localparam wbs_state_t ST_BUSY = 2'd1;
  localparam wbs_state_t ST_RESP = 2'd2;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/surfturf_wb_splitter.sv
// surfturf_wb_splitter
//   Splits one upstream Wishbone initiator onto NUM_SLV windowed targets plus
//   one auxiliary target that owns the upper half of the address space.
//   One transaction is in flight at a time: IDLE accepts, BUSY waits for the
//   selected target (bounded by TIMEOUT), RESP returns a one-cycle ack/err.
//
// Ports
//   wb_clk_i, wb_rst_n_i        clock, synchronous active-low reset
//   wb_cyc/stb/we/adr/dat/sel_i upstream request
//   wb_ack/err/rty_o, wb_dat_o  upstream response (rty is always 0)
//   s_*                         per-target request/response lanes, flattened
//   aux_*                       auxiliary target (adr[ADR_W-1] = 1)
//   timeout_cnt_o               saturating count of timeouts
//   err_adr_o                   address of the most recent errored access
module surfturf_wb_splitter
  import surfturf_wb_splitter_pkg::*;
#(
  parameter int NUM_SLV = SURFTURF_NUM_SLV_DEF,
  parameter int SLV_AW  = SURFTURF_SLV_AW_DEF,
  parameter int ADR_W   = SURFTURF_ADR_W_DEF,
  parameter int TIMEOUT = SURFTURF_TIMEOUT_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADR_W-1:0]        wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  input  logic [3:0]              wb_sel_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [31:0]             wb_dat_o,
  output logic [NUM_SLV-1:0]      s_cyc_o,
  output logic [NUM_SLV-1:0]      s_stb_o,
  output logic [NUM_SLV-1:0]      s_we_o,
  output logic [NUM_SLV*SLV_AW-1:0] s_adr_o,
  output logic [NUM_SLV*32-1:0]   s_dat_o,
  output logic [NUM_SLV*4-1:0]    s_sel_o,
  input  logic [NUM_SLV-1:0]      s_ack_i,
  input  logic [NUM_SLV-1:0]      s_err_i,
  input  logic [NUM_SLV*32-1:0]   s_dat_i,
  output logic                    aux_cyc_o,
  output logic                    aux_stb_o,
  output logic                    aux_we_o,
  output logic [ADR_W-3:0]        aux_adr_o,
  output logic [31:0]             aux_dat_o,
  output logic [3:0]              aux_sel_o,
  input  logic                    aux_ack_i,
  input  logic [31:0]             aux_dat_i,
  output logic [7:0]              timeout_cnt_o,
  output logic [ADR_W-1:0]        err_adr_o
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [IDX_W:0] NUM_SLV_L = (IDX_W + 1)'(NUM_SLV);
  localparam logic [15:0]    TMO_LAST  = 16'(TIMEOUT - 1);

  // Address bits between the target index and the aux-select bit; any of
  // them set means the address falls in a hole of the lower half.
  function automatic logic [ADR_W-1:0] pad_mask();
    logic [ADR_W-1:0] m;
    m = '0;
    for (int i = 0; i < ADR_W; i++) begin
      m[i] = (i >= SLV_AW + IDX_W) && (i <= ADR_W - 2);
    end
    return m;
  endfunction

  localparam logic [ADR_W-1:0] PAD_MASK = pad_mask();

  wbs_state_t        state_r;
  logic [ADR_W-1:0]  adr_r;
  logic [31:0]       dat_r;
  logic [3:0]        sel_r;
  logic              we_r;
  logic [NUM_SLV-1:0] s_stb_r;
  logic              aux_stb_r;
  logic [15:0]       tmo_r;
  logic              ack_r;
  logic              err_r;
  logic [31:0]       wb_dat_r;
  logic [7:0]        timeout_cnt_r;
  logic [ADR_W-1:0]  err_adr_r;

  logic              dec_aux_s;
  logic [IDX_W-1:0]  dec_idx_s;
  logic              dec_unmapped_s;
  logic [NUM_SLV-1:0] dec_onehot_s;
  logic              rsp_ack_s;
  logic              rsp_err_s;
  logic [31:0]       rsp_dat_s;

  // Decode the live upstream address into aux / target one-hot / unmapped.
  always_comb begin
    dec_aux_s      = wb_adr_i[ADR_W-1];
    dec_idx_s      = wb_adr_i[SLV_AW +: IDX_W];
    dec_unmapped_s = !dec_aux_s &&
                     (({1'b0, dec_idx_s} >= NUM_SLV_L) || (|(wb_adr_i & PAD_MASK)));
    dec_onehot_s   = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      dec_onehot_s[i] = (dec_idx_s == i[IDX_W-1:0]);
    end
  end

  // Response mux: the registered one-hot strobe doubles as the lane select,
  // so only the addressed target can ack, err or supply data.
  always_comb begin
    rsp_dat_s = aux_stb_r ? aux_dat_i : 32'h0000_0000;
    for (int i = 0; i < NUM_SLV; i++) begin
      rsp_dat_s = rsp_dat_s | (s_dat_i[i*32 +: 32] & {32{s_stb_r[i]}});
    end
    rsp_ack_s = (aux_stb_r & aux_ack_i) | (|(s_ack_i & s_stb_r));
    rsp_err_s = |(s_err_i & s_stb_r);
  end

  // Transaction FSM with registered downstream strobes and upstream response.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_r       <= ST_IDLE;
      adr_r         <= '0;
      dat_r         <= 32'h0000_0000;
      sel_r         <= 4'h0;
      we_r          <= 1'b0;
      s_stb_r       <= '0;
      aux_stb_r     <= 1'b0;
      tmo_r         <= 16'h0000;
      ack_r         <= 1'b0;
      err_r         <= 1'b0;
      wb_dat_r      <= 32'h0000_0000;
      timeout_cnt_r <= 8'h00;
      err_adr_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            adr_r <= wb_adr_i;
            dat_r <= wb_dat_i;
            sel_r <= wb_sel_i;
            we_r  <= wb_we_i;
            tmo_r <= 16'h0000;
            if (dec_unmapped_s) begin
              // Holes answer immediately without touching any target.
              state_r   <= ST_RESP;
              err_r     <= 1'b1;
              wb_dat_r  <= 32'h0000_0000;
              err_adr_r <= wb_adr_i;
            end else begin
              state_r   <= ST_BUSY;
              s_stb_r   <= dec_aux_s ? '0 : dec_onehot_s;
              aux_stb_r <= dec_aux_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (!wb_cyc_i) begin
            // Initiator abandoned the cycle: quietly release the target.
            state_r   <= ST_IDLE;
            s_stb_r   <= '0;
            aux_stb_r <= 1'b0;
          end else if (rsp_err_s) begin
            // Checked before ack so a simultaneous ack+err reports err.
            state_r   <= ST_RESP;
            s_stb_r   <= '0;
            aux_stb_r <= 1'b0;
            err_r     <= 1'b1;
            wb_dat_r  <= 32'h0000_0000;
            err_adr_r <= adr_r;
          end else if (rsp_ack_s) begin
            state_r   <= ST_RESP;
            s_stb_r   <= '0;
            aux_stb_r <= 1'b0;
            ack_r     <= 1'b1;
            wb_dat_r  <= rsp_dat_s;
          end else if (tmo_r == TMO_LAST) begin
            state_r       <= ST_RESP;
            s_stb_r       <= '0;
            aux_stb_r     <= 1'b0;
            err_r         <= 1'b1;
            wb_dat_r      <= 32'h0000_0000;
            err_adr_r     <= adr_r;
            timeout_cnt_r <= sat_inc8(timeout_cnt_r);
          end else begin
            tmo_r <= tmo_r + 16'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          s_stb_r   <= '0;
          aux_stb_r <= 1'b0;
          ack_r     <= 1'b0;
          err_r     <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o      = ack_r;
  assign wb_err_o      = err_r;
  assign wb_rty_o      = 1'b0;
  assign wb_dat_o      = wb_dat_r;

  // The registered request is broadcast; only cyc/stb qualify a lane.
  assign s_cyc_o       = s_stb_r;
  assign s_stb_o       = s_stb_r;
  assign s_we_o        = {NUM_SLV{we_r}};
  assign s_adr_o       = {NUM_SLV{adr_r[SLV_AW-1:0]}};
  assign s_dat_o       = {NUM_SLV{dat_r}};
  assign s_sel_o       = {NUM_SLV{sel_r}};

  assign aux_cyc_o     = aux_stb_r;
  assign aux_stb_o     = aux_stb_r;
  assign aux_we_o      = we_r;
  assign aux_adr_o     = adr_r[ADR_W-3:0];
  assign aux_dat_o     = dat_r;
  assign aux_sel_o     = sel_r;

  assign timeout_cnt_o = timeout_cnt_r;
  assign err_adr_o     = err_adr_r;

endmodule

// File: tb/tb_surfturf_wb_splitter.sv
// Self-checking bench for surfturf_wb_splitter (NUM_SLV=7, TIMEOUT=16).
module tb_surfturf_wb_splitter;

  localparam int NS   = 7;
  localparam int AW   = 6;
  localparam int ADRW = 12;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              wb_cyc, wb_stb, wb_we;
  logic [ADRW-1:0]   wb_adr;
  logic [31:0]       wb_dat;
  logic [3:0]        wb_sel;
  logic              wb_ack, wb_err, wb_rty;
  logic [31:0]       wb_rdat;
  logic [NS-1:0]     s_cyc, s_stb, s_we;
  logic [NS*AW-1:0]  s_adr;
  logic [NS*32-1:0]  s_wdat, s_rdat;
  logic [NS*4-1:0]   s_sel;
  logic [NS-1:0]     s_ack, s_err;
  logic              aux_cyc, aux_stb, aux_we;
  logic [ADRW-3:0]   aux_adr;
  logic [31:0]       aux_wdat, aux_rdat;
  logic [3:0]        aux_sel;
  logic              aux_ack;
  logic [7:0]        tmo_cnt;
  logic [ADRW-1:0]   err_adr;

  surfturf_wb_splitter #(.NUM_SLV(NS), .SLV_AW(AW), .ADR_W(ADRW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty), .wb_dat_o(wb_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_rdat),
    .aux_cyc_o(aux_cyc), .aux_stb_o(aux_stb), .aux_we_o(aux_we), .aux_adr_o(aux_adr),
    .aux_dat_o(aux_wdat), .aux_sel_o(aux_sel), .aux_ack_i(aux_ack), .aux_dat_i(aux_rdat),
    .timeout_cnt_o(tmo_cnt), .err_adr_o(err_adr)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int              m_tmo_cnt;
  logic [ADRW-1:0] m_err_adr;

  // observations of the last transaction
  int              obs_stb_c, obs_resp_c, obs_pulses;
  logic            obs_ack, obs_err, obs_bad, obs_after, obs_cycmis;
  logic [NS-1:0]   obs_vec;
  logic            obs_aux, obs_we;
  logic [9:0]      obs_adr;
  logic [31:0]     obs_wdat, obs_rdat, obs_rdat_hold;
  logic [3:0]      obs_sel;

  // Address map from the window rules: upper half -> aux (returns NS),
  // 64-byte windows below it, anything else -> -1.
  function automatic int ref_target(input logic [ADRW-1:0] a);
    int av;
    av = int'(a);
    if (av >= 2048) return NS;
    if (av / 512 != 0) return -1;
    if ((av / 64) % 8 >= NS) return -1;
    return (av / 64) % 8;
  endfunction

  // Drive one request in cycle 0 and act as the addressed target.
  // kind: 0 ack, 1 err, 2 ack+err together, 3 never respond.
  task automatic run_txn(input logic [ADRW-1:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, input int kind, input int dly,
                         input logic [31:0] rdat);
    obs_stb_c = -1; obs_resp_c = -1; obs_pulses = 0;
    obs_ack = 1'b0; obs_err = 1'b0; obs_bad = 1'b0; obs_after = 1'b0; obs_cycmis = 1'b0;
    obs_vec = '0; obs_aux = 1'b0; obs_we = 1'b0; obs_adr = '0; obs_sel = 4'h0;
    obs_wdat = 32'h0; obs_rdat = 32'h0; obs_rdat_hold = 32'h0;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = wdat; wb_sel = sel;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_cyc !== s_stb || aux_cyc !== aux_stb) obs_cycmis = 1'b1;
      if (wb_ack === 1'b1 || wb_err === 1'b1) begin
        obs_pulses++;
        if (obs_resp_c < 0) begin
          obs_resp_c = c; obs_ack = wb_ack; obs_err = wb_err; obs_rdat = wb_rdat;
        end
      end
      if (obs_resp_c >= 0) begin
        if (s_stb != '0 || aux_stb === 1'b1) obs_after = 1'b1;
        if (c > obs_resp_c) begin
          obs_rdat_hold = wb_rdat;
          break;
        end
      end else if (s_stb != '0 || aux_stb === 1'b1) begin
        if (obs_stb_c < 0) begin
          obs_stb_c = c; obs_vec = s_stb; obs_aux = aux_stb;
          for (int i = 0; i < NS; i++) begin
            if (s_stb[i]) begin
              obs_adr = 10'(s_adr[i*AW +: AW]); obs_wdat = s_wdat[i*32 +: 32];
              obs_sel = s_sel[i*4 +: 4]; obs_we = s_we[i];
            end
          end
          if (aux_stb) begin
            obs_adr = aux_adr; obs_wdat = aux_wdat; obs_sel = aux_sel; obs_we = aux_we;
          end
        end else if (s_stb !== obs_vec || aux_stb !== obs_aux) begin
          obs_bad = 1'b1;
        end
        for (int i = 0; i < NS; i++) s_rdat[i*32 +: 32] = s_stb[i] ? rdat : ~rdat;
        aux_rdat = aux_stb ? rdat : ~rdat;
        if (kind != 3 && c == obs_stb_c + dly) begin
          if (kind == 0 || kind == 2) begin s_ack = s_stb; aux_ack = aux_stb; end
          if (kind == 1 || kind == 2) s_err = s_stb;
        end
      end
      @(posedge clk); #1;
      s_ack = '0; s_err = '0; aux_ack = 1'b0;
      if (obs_resp_c >= 0) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
    wb_dat = 32'h0; wb_sel = 4'h0; s_ack = '0; s_err = '0; s_rdat = '0;
    aux_ack = 1'b0; aux_rdat = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_cyc, s_stb, aux_cyc, aux_stb} !== '0) begin
      errors++; $display("FAIL reset_strobes: got %h want 0", {s_cyc, s_stb, aux_cyc, aux_stb});
    end
    checks++;
    if ({wb_ack, wb_err, wb_rty} !== 3'b000) begin
      errors++; $display("FAIL reset_resp: got %b want 000", {wb_ack, wb_err, wb_rty});
    end
    checks++;
    if (wb_rdat !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", wb_rdat); end
    checks++;
    if (tmo_cnt !== 8'h0 || err_adr !== 12'h0) begin
      errors++; $display("FAIL reset_stats: got %h/%h want 0/0", tmo_cnt, err_adr);
    end
    m_tmo_cnt = 0; m_err_adr = '0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_read_0c4();
    run_txn(12'h0C4, 1'b0, 32'h0, 4'hF, 0, 3, 32'hDEADBEEF);
    checks++;
    if (obs_vec !== 7'b0001000 || obs_aux !== 1'b0 || obs_stb_c != 1) begin
      errors++; $display("FAIL rd_select: got vec %b aux %b cyc %0d want 0001000 0 1", obs_vec, obs_aux, obs_stb_c);
    end
    checks++;
    if (obs_adr !== 10'h004) begin errors++; $display("FAIL rd_offset: got %h want 004", obs_adr); end
    checks++;
    if (obs_resp_c != 5 || obs_ack !== 1'b1 || obs_err !== 1'b0) begin
      errors++; $display("FAIL rd_ack: got cyc %0d ack %b err %b want 5 1 0", obs_resp_c, obs_ack, obs_err);
    end
    checks++;
    if (obs_rdat !== 32'hDEADBEEF || obs_rdat_hold !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data: got %h/%h want deadbeef", obs_rdat, obs_rdat_hold);
    end
  endtask

  task automatic test_write_aux();
    run_txn(12'h840, 1'b1, 32'h1234_5678, 4'h3, 0, 2, 32'h0BAD_F00D);
    checks++;
    if (obs_aux !== 1'b1 || obs_vec !== '0 || obs_adr !== 10'h040) begin
      errors++; $display("FAIL aux_select: got aux %b vec %b adr %h want 1 0 040", obs_aux, obs_vec, obs_adr);
    end
    checks++;
    if (obs_we !== 1'b1 || obs_wdat !== 32'h1234_5678 || obs_sel !== 4'h3) begin
      errors++; $display("FAIL aux_wr: got we %b dat %h sel %h want 1 12345678 3", obs_we, obs_wdat, obs_sel);
    end
    checks++;
    if (obs_resp_c != 4 || obs_ack !== 1'b1 || obs_rdat !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL aux_ack: got cyc %0d ack %b dat %h want 4 1 0badf00d", obs_resp_c, obs_ack, obs_rdat);
    end
  endtask

  task automatic test_unmapped();
    run_txn(12'h1C0, 1'b0, 32'h0, 4'hF, 0, 0, 32'h5555_5555);
    m_err_adr = 12'h1C0;
    checks++;
    if (obs_stb_c != -1 || obs_resp_c != 1 || obs_err !== 1'b1 || obs_ack !== 1'b0) begin
      errors++; $display("FAIL unmapped: got stb %0d resp %0d err %b ack %b want -1 1 1 0", obs_stb_c, obs_resp_c, obs_err, obs_ack);
    end
    checks++;
    if (err_adr !== m_err_adr || obs_rdat !== 32'h0) begin
      errors++; $display("FAIL unmapped_adr: got %h dat %h want %h 0", err_adr, obs_rdat, m_err_adr);
    end
  endtask

  task automatic test_timeout();
    run_txn(12'h080, 1'b0, 32'h0, 4'hF, 3, 0, 32'h0);
    m_tmo_cnt = 1; m_err_adr = 12'h080;
    checks++;
    if (obs_resp_c != TMO + 1 || obs_err !== 1'b1 || obs_pulses != 1 || obs_after !== 1'b0) begin
      errors++; $display("FAIL timeout: got cyc %0d err %b pulses %0d after %b want %0d 1 1 0", obs_resp_c, obs_err, obs_pulses, obs_after, TMO + 1);
    end
    checks++;
    if (tmo_cnt !== 8'(m_tmo_cnt) || err_adr !== m_err_adr) begin
      errors++; $display("FAIL timeout_stats: got %0d/%h want %0d/%h", tmo_cnt, err_adr, m_tmo_cnt, m_err_adr);
    end
  endtask

  task automatic test_abort();
    logic any_rsp;
    any_rsp = 1'b0;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 12'h140;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wb_ack === 1'b1 || wb_err === 1'b1) any_rsp = 1'b1;
      @(posedge clk); #1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (s_cyc !== 7'b0100000) begin errors++; $display("FAIL abort_busy: got %b want 0100000", s_cyc); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_cyc !== '0 || s_stb !== '0 || aux_cyc !== 1'b0) begin
      errors++; $display("FAIL abort_drop: got %b/%b want 0", s_cyc, s_stb);
    end
    for (int c = 0; c < 24; c++) begin
      if (wb_ack === 1'b1 || wb_err === 1'b1) any_rsp = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (any_rsp !== 1'b0) begin errors++; $display("FAIL abort_rsp: got %b want 0", any_rsp); end
    checks++;
    if (tmo_cnt !== 8'(m_tmo_cnt)) begin errors++; $display("FAIL abort_tmo: got %0d want %0d", tmo_cnt, m_tmo_cnt); end
  endtask

  task automatic test_random();
    logic [ADRW-1:0] adr;
    logic [31:0] wdat, rdat, exp_dat;
    logic [NS-1:0] exp_vec;
    logic [9:0] exp_adr;
    logic [3:0] sel;
    logic we, exp_err;
    int tgt, kind, dly, r, exp_c;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    adr = 12'($urandom_range(0, NS - 1) * 64 + $urandom_range(0, 63));
        2:       adr = 12'(2048 + $urandom_range(0, 2047));
        3:       adr = 12'(7 * 64 + $urandom_range(0, 63));
        default: adr = 12'($urandom_range(0, 4095));
      endcase
      tgt = ref_target(adr);
      r = int'($urandom_range(0, 7));
      if (tgt == NS) kind = (r == 6) ? 3 : 0;
      else kind = (r == 4) ? 1 : (r == 5) ? 2 : (r == 6) ? 3 : 0;
      dly = int'($urandom_range(0, 5));
      we = 1'($urandom); wdat = $urandom; rdat = $urandom; sel = 4'($urandom);
      run_txn(adr, we, wdat, sel, kind, dly, rdat);
      exp_err = (tgt < 0) || (kind != 0);
      exp_c   = (tgt < 0) ? 1 : (kind == 3) ? TMO + 1 : dly + 2;
      exp_dat = exp_err ? 32'h0 : rdat;
      exp_vec = '0;
      if (tgt >= 0 && tgt < NS) exp_vec[tgt] = 1'b1;
      exp_adr = (tgt == NS) ? adr[9:0] : 10'(adr[5:0]);
      if (exp_err) m_err_adr = adr;
      if (tgt >= 0 && kind == 3 && m_tmo_cnt < 255) m_tmo_cnt++;
      checks++;
      if (obs_resp_c != exp_c || obs_err !== exp_err || obs_ack !== !exp_err || obs_pulses != 1) begin
        errors++; $display("FAIL rnd_resp #%0d adr %h: got cyc %0d err %b ack %b n %0d want %0d %b %b 1", n, adr, obs_resp_c, obs_err, obs_ack, obs_pulses, exp_c, exp_err, !exp_err);
      end
      checks++;
      if (obs_rdat !== exp_dat || obs_rdat_hold !== exp_dat) begin
        errors++; $display("FAIL rnd_rdat #%0d: got %h/%h want %h", n, obs_rdat, obs_rdat_hold, exp_dat);
      end
      checks++;
      if (obs_vec !== exp_vec || obs_aux !== (tgt == NS) || obs_stb_c != ((tgt < 0) ? -1 : 1)) begin
        errors++; $display("FAIL rnd_sel #%0d adr %h: got %b/%b c %0d want %b/%b", n, adr, obs_vec, obs_aux, obs_stb_c, exp_vec, tgt == NS);
      end
      if (tgt >= 0) begin
        checks++;
        if (obs_adr !== exp_adr || obs_wdat !== wdat || obs_sel !== sel || obs_we !== we) begin
          errors++; $display("FAIL rnd_req #%0d: got %h %h %h %b want %h %h %h %b", n, obs_adr, obs_wdat, obs_sel, obs_we, exp_adr, wdat, sel, we);
        end
      end
      checks++;
      if (obs_bad !== 1'b0 || obs_after !== 1'b0 || obs_cycmis !== 1'b0) begin
        errors++; $display("FAIL rnd_strobe #%0d: got bad %b after %b cycmis %b want 0 0 0", n, obs_bad, obs_after, obs_cycmis);
      end
      checks++;
      if (err_adr !== m_err_adr || tmo_cnt !== 8'(m_tmo_cnt)) begin
        errors++; $display("FAIL rnd_stats #%0d: got %h/%0d want %h/%0d", n, err_adr, tmo_cnt, m_err_adr, m_tmo_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    logic [ADRW-1:0] adr;
    for (int n = 0; n < 300; n++) begin
      adr = 12'($urandom_range(0, NS - 1) * 64 + $urandom_range(0, 63));
      run_txn(adr, 1'b0, 32'h0, 4'hF, 3, 0, 32'h0);
      if (m_tmo_cnt < 255) m_tmo_cnt++;
      m_err_adr = adr;
      checks++;
      if (tmo_cnt !== 8'(m_tmo_cnt) || obs_err !== 1'b1) begin
        errors++; $display("FAIL sat_cnt #%0d: got %0d err %b want %0d 1", n, tmo_cnt, obs_err, m_tmo_cnt);
      end
    end
    checks++;
    if (tmo_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", tmo_cnt); end
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 12'h0C4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_cyc, s_stb, aux_cyc, aux_stb, wb_ack, wb_err} !== '0) begin
      errors++; $display("FAIL rstbusy_ctl: got %b want 0", {s_cyc, s_stb, aux_cyc, aux_stb, wb_ack, wb_err});
    end
    checks++;
    if (wb_rdat !== 32'h0 || tmo_cnt !== 8'h0 || err_adr !== 12'h0) begin
      errors++; $display("FAIL rstbusy_regs: got %h %0d %h want 0 0 0", wb_rdat, tmo_cnt, err_adr);
    end
    m_tmo_cnt = 0; m_err_adr = '0;
    run_txn(12'h188, 1'b0, 32'h0, 4'hF, 0, 1, 32'hCAFE_0188);
    checks++;
    if (obs_vec !== 7'b1000000 || obs_resp_c != 3 || obs_ack !== 1'b1 || obs_rdat !== 32'hCAFE_0188) begin
      errors++; $display("FAIL rstbusy_next: got %b cyc %0d ack %b dat %h want 1000000 3 1 cafe0188", obs_vec, obs_resp_c, obs_ack, obs_rdat);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_0c4();
    test_write_aux();
    test_unmapped();
    test_timeout();
    test_abort();
    test_random();
    test_saturation();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
